adc_fft_if_uram_arb: RTL and testbench

Arbiter and sequencer for the 256 x 32 FFT scratch RAM: one write port (C) and one registered read port (A). It shares the write port between the ADC sample loader (w0) and the FFT result write-back (w1). It shares the read port between the FFT operand fetch (r0) and the host unload path (r1). It also resolves read-during-write hazards and tags returned read data back to the requester that issued it. It sits between the adc_fft_if front end / COREFFT engine and the scratch RAM instance.

---
 rtl/adc_fft_if_uram_arb.sv | 121 ++++++++++++
 tb/tb_adc_fft_if_uram_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fft_if_uram_arb.sv
// Write/read port arbiter for the FFT scratch RAM: shares port C between the ADC
// loader and FFT write-back, port A between FFT fetch and host unload, with hazard stall.
module adc_fft_if_uram_arb #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int RD_LAT  = 2,
   parameter int W0_PRIO = 0
) (
   input  logic          clk,
   input  logic          nGrst,
   input  logic          w0_req,
   input  logic          w1_req,
   input  logic [AW-1:0] w0_addr,
   input  logic [AW-1:0] w1_addr,
   input  logic [DW-1:0] w0_data,
   input  logic [DW-1:0] w1_data,
   output logic          w0_gnt,
   output logic          w1_gnt,
   input  logic          r0_req,
   input  logic          r1_req,
   input  logic [AW-1:0] r0_addr,
   input  logic [AW-1:0] r1_addr,
   output logic          r0_gnt,
   output logic          r1_gnt,
   output logic          r0_valid,
   output logic          r1_valid,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] wAddr,
   output logic [DW-1:0] wD,
   output logic          wEn,
   output logic          wBlk,
   output logic [AW-1:0] rAddr,
   output logic          rBlk,
   input  logic [DW-1:0] rD,
   output logic [15:0]   hazard_cnt
);

   logic              wlast_q, wlast_d;
   logic              rlast_q, rlast_d;
   logic [15:0]       hazard_cnt_q, hazard_cnt_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0] tag_id_q, tag_id_d;

   logic          w_sel, w_any;
   logic          r_sel, r_cand, r_any, hazard;
   logic [AW-1:0] r_addr_c;

   always_comb begin
      w_sel        = 1'b0;
      w_any        = 1'b0;
      r_sel        = 1'b0;
      r_cand       = 1'b0;
      r_any        = 1'b0;
      hazard       = 1'b0;
      r_addr_c     = r0_addr;
      wlast_d      = wlast_q;
      rlast_d      = rlast_q;
      hazard_cnt_d = hazard_cnt_q;
      tag_vld_d    = '0;
      tag_id_d     = '0;

      // Last-winner pointers: on contention the other requester wins.
      if (w0_req && w1_req) w_sel = (W0_PRIO != 0) ? 1'b0 : ~wlast_q;
      else                  w_sel = w1_req & ~w0_req;
      w_any = (w0_req | w1_req) & nGrst;

      if (r0_req && r1_req) r_sel = ~rlast_q;
      else                  r_sel = r1_req & ~r0_req;
      r_cand   = (r0_req | r1_req) & nGrst;
      r_addr_c = r_sel ? r1_addr : r0_addr;

      wAddr = w_sel ? w1_addr : w0_addr;
      // Same-address write wins; the read retries next cycle and sees the new data.
      hazard = r_cand & w_any & (r_addr_c == wAddr);
      r_any  = r_cand & ~hazard;

      if (w0_req && w1_req && w_any) wlast_d = w_sel;
      if (r0_req && r1_req && r_any) rlast_d = r_sel;
      if (hazard && (hazard_cnt_q != 16'hFFFF)) hazard_cnt_d = hazard_cnt_q + 16'd1;

      tag_vld_d[0] = r_any;
      tag_id_d[0]  = r_sel;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign wD     = w_sel ? w1_data : w0_data;
   assign wEn    = w_any;
   assign wBlk   = w_any;
   assign w0_gnt = w_any & ~w_sel;
   assign w1_gnt = w_any & w_sel;

   assign rAddr  = r_addr_c;
   assign rBlk   = r_any;
   assign r0_gnt = r_any & ~r_sel;
   assign r1_gnt = r_any & r_sel;

   assign r0_valid   = tag_vld_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
   assign r1_valid   = tag_vld_q[RD_LAT-1] & tag_id_q[RD_LAT-1];
   assign rd_data    = rD;
   assign hazard_cnt = hazard_cnt_q;

   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         wlast_q      <= 1'b1;
         rlast_q      <= 1'b1;
         hazard_cnt_q <= '0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
      end else begin
         wlast_q      <= wlast_d;
         rlast_q      <= rlast_d;
         hazard_cnt_q <= hazard_cnt_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
      end
   end

endmodule

// File: tb/tb_adc_fft_if_uram_arb.sv
// Bench for adc_fft_if_uram_arb: RAM model, per-cycle reference model of the arbitration
// rules and return order, plus directed scenarios with literal expectations.
module tb_adc_fft_if_uram_arb;
   localparam int AW = 8, DW = 32, RD_LAT = 2;

   logic clk = 1'b0, nGrst;
   logic w0_req, w1_req, r0_req, r1_req;
   logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
   logic [DW-1:0] w0_data, w1_data;
   logic w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_valid, r1_valid;
   logic [DW-1:0] rd_data, wD, rD;
   logic [AW-1:0] wAddr, rAddr;
   logic wEn, wBlk, rBlk;
   logic [15:0] hazard_cnt;

   logic p_w0_gnt, p_w1_gnt, p_r0_gnt, p_r1_gnt, p_r0_valid, p_r1_valid;
   logic [DW-1:0] p_rd_data, p_wD;
   logic [AW-1:0] p_wAddr, p_rAddr;
   logic p_wEn, p_wBlk, p_rBlk;
   logic [15:0] p_hazard_cnt;

   always #5 clk = ~clk;

   adc_fft_if_uram_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .W0_PRIO(0)) dut (
      .clk(clk), .nGrst(nGrst),
      .w0_req(w0_req), .w1_req(w1_req), .w0_addr(w0_addr), .w1_addr(w1_addr),
      .w0_data(w0_data), .w1_data(w1_data), .w0_gnt(w0_gnt), .w1_gnt(w1_gnt),
      .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_valid(r0_valid), .r1_valid(r1_valid),
      .rd_data(rd_data), .wAddr(wAddr), .wD(wD), .wEn(wEn), .wBlk(wBlk),
      .rAddr(rAddr), .rBlk(rBlk), .rD(rD), .hazard_cnt(hazard_cnt));

   adc_fft_if_uram_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .W0_PRIO(1)) dut_p (
      .clk(clk), .nGrst(nGrst),
      .w0_req(w0_req), .w1_req(w1_req), .w0_addr(w0_addr), .w1_addr(w1_addr),
      .w0_data(w0_data), .w1_data(w1_data), .w0_gnt(p_w0_gnt), .w1_gnt(p_w1_gnt),
      .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_gnt(p_r0_gnt), .r1_gnt(p_r1_gnt), .r0_valid(p_r0_valid), .r1_valid(p_r1_valid),
      .rd_data(p_rd_data), .wAddr(p_wAddr), .wD(p_wD), .wEn(p_wEn), .wBlk(p_wBlk),
      .rAddr(p_rAddr), .rBlk(p_rBlk), .rD(rD), .hazard_cnt(p_hazard_cnt));

   // Scratch RAM: registered read address plus output register.
   logic [DW-1:0] mem [0:255];
   logic [AW-1:0] ra_q;
   always @(posedge clk) begin
      if (wEn && wBlk) mem[wAddr] <= wD;
      if (rBlk) ra_q <= rAddr;
      rD <= mem[ra_q];
   end

   int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 50)
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model
   typedef struct { int due; bit id; logic [31:0] data; } ret_t;
   ret_t    rq[$];
   ret_t    ent;
   logic [31:0] mmem [0:255];
   bit      wl = 1, rl = 1;
   int      hcnt = 0;
   bit      ew0, ew1, er0c, er1c, er0, er1, haz, ev0, ev1;
   logic [7:0]  wa, ra;
   logic [31:0] wdat;

   initial for (int i = 0; i < 256; i++) begin mem[i] = '0; mmem[i] = '0; end

   always @(negedge clk) begin
      if (!nGrst) begin
         chk("rst_outputs", {24'd0, w0_gnt, w1_gnt, r0_gnt, r1_gnt, wEn, wBlk, rBlk,
             r0_valid | r1_valid}, 32'd0);
         chk("rst_hazard_cnt", {16'd0, hazard_cnt}, 32'd0);
         rq.delete();
         wl = 1; rl = 1; hcnt = 0;
      end else begin
         ew0  = w0_req && (!w1_req || wl);
         ew1  = w1_req && !ew0;
         wa   = ew1 ? w1_addr : w0_addr;
         wdat = ew1 ? w1_data : w0_data;
         er0c = r0_req && (!r1_req || rl);
         er1c = r1_req && !er0c;
         ra   = er1c ? r1_addr : r0_addr;
         haz  = (er0c || er1c) && (ew0 || ew1) && (ra == wa);
         er0  = er0c && !haz;
         er1  = er1c && !haz;
         ev0  = 0; ev1 = 0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            ev0 = !rq[0].id; ev1 = rq[0].id;
         end

         chk("w_gnt", {30'd0, w0_gnt, w1_gnt}, {30'd0, ew0, ew1});
         chk("w_en_blk", {30'd0, wEn, wBlk}, {30'd0, ew0 | ew1, ew0 | ew1});
         chk("prio_w_gnt", {30'd0, p_w0_gnt, p_w1_gnt}, {30'd0, w0_req, w1_req & ~w0_req});
         chk("r_gnt", {30'd0, r0_gnt, r1_gnt}, {30'd0, er0, er1});
         chk("r_blk", {31'd0, rBlk}, {31'd0, er0 | er1});
         chk("r_valid", {30'd0, r0_valid, r1_valid}, {30'd0, ev0, ev1});
         chk("hazard_cnt", {16'd0, hazard_cnt}, hcnt[31:0]);
         if (ew0 || ew1) begin
            chk("w_addr", {24'd0, wAddr}, {24'd0, wa});
            chk("w_data", wD, wdat);
         end
         if (er0 || er1) chk("r_addr", {24'd0, rAddr}, {24'd0, ra});
         if (ev0 || ev1) begin
            chk("rd_data", rd_data, rq[0].data);
            void'(rq.pop_front());
         end

         if (er0 || er1) begin
            ent.due = cyc + RD_LAT; ent.id = er1; ent.data = mmem[ra];
            rq.push_back(ent);
         end
         if (ew0 || ew1) mmem[wa] = wdat;
         if (w0_req && w1_req) wl = ew1;
         if (r0_req && r1_req && (er0 || er1)) rl = er1;
         if (haz && hcnt < 65535) hcnt++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   logic [3:0] g0, g1, gp0, gp1;
   logic [5:0] rg0;
   logic [8:0] v0, v1;

   initial begin
      nGrst = 0;
      w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
      w0_addr = 0; w1_addr = 0; r0_addr = 0; r1_addr = 0;
      w0_data = 0; w1_data = 0;
      repeat (3) tick();
      nGrst = 1;
      @(negedge clk);
      chk("idle_outputs", {24'd0, w0_gnt, w1_gnt, r0_gnt, r1_gnt, wEn, rBlk, r0_valid,
          r1_valid}, 32'd0);
      chk("idle_hazard", {16'd0, hazard_cnt}, 32'd0);

      // single write then read-back on r1
      tick();
      w0_req = 1; w0_addr = 8'h10; w0_data = 32'hDEADBEEF;
      @(negedge clk); chk("wr_gnt", {31'd0, w0_gnt}, 32'd1);
      tick(); w0_req = 0;
      r1_req = 1; r1_addr = 8'h10;
      @(negedge clk); chk("rd1_gnt", {31'd0, r1_gnt}, 32'd1);
      tick(); r1_req = 0;
      @(negedge clk); chk("rd1_early", {30'd0, r0_valid, r1_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd1_valid", {30'd0, r0_valid, r1_valid}, 32'd1);
      chk("rd1_data", rd_data, 32'hDEADBEEF);
      tick();

      // contested writes
      for (int i = 0; i < 4; i++) begin
         w0_req = 1; w1_req = 1; w0_addr = 8'(i); w1_addr = 8'(i);
         w0_data = 32'h1000 + i; w1_data = 32'h2000 + i;
         @(negedge clk);
         g0[i] = w0_gnt; g1[i] = w1_gnt; gp0[i] = p_w0_gnt; gp1[i] = p_w1_gnt;
         tick();
      end
      w0_req = 0; w1_req = 0;
      chk("rr_w0_pattern", {28'd0, g0}, 32'h5);
      chk("rr_w1_pattern", {28'd0, g1}, 32'hA);
      chk("prio_w0_pattern", {28'd0, gp0}, 32'hF);
      chk("prio_w1_pattern", {28'd0, gp1}, 32'h0);

      // contested reads, return order
      for (int j = 0; j < 9; j++) begin
         if (j < 6) begin
            r0_req = 1; r1_req = 1; r0_addr = 8'(j % 4); r1_addr = 8'h10;
         end else begin
            r0_req = 0; r1_req = 0;
         end
         @(negedge clk);
         if (j < 6) rg0[j] = r0_gnt;
         v0[j] = r0_valid; v1[j] = r1_valid;
         tick();
      end
      chk("rr_r0_pattern", {26'd0, rg0}, 32'h15);
      chk("rr_v0_pattern", {23'd0, v0}, 32'h054);
      chk("rr_v1_pattern", {23'd0, v1}, 32'h0A8);

      // read-during-write hazard
      w1_req = 1; w1_addr = 8'h20; w1_data = 32'h55;
      r0_req = 1; r0_addr = 8'h20;
      @(negedge clk);
      chk("haz_r0_gnt", {31'd0, r0_gnt}, 32'd0);
      chk("haz_w1_gnt", {31'd0, w1_gnt}, 32'd1);
      tick(); w1_req = 0;
      @(negedge clk);
      chk("haz_cnt_one", {16'd0, hazard_cnt}, 32'd1);
      chk("haz_retry_gnt", {31'd0, r0_gnt}, 32'd1);
      tick(); r0_req = 0;
      tick();
      @(negedge clk);
      chk("haz_ret_valid", {30'd0, r0_valid, r1_valid}, 32'd2);
      chk("haz_ret_data", rd_data, 32'h55);
      tick();

      // reset with a read in flight
      w0_req = 1; w1_req = 1; w0_addr = 8'h40; w1_addr = 8'h40;
      r0_req = 1; r1_req = 1; r0_addr = 8'h41; r1_addr = 8'h42;
      @(negedge clk);
      chk("pre_rst_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      tick();
      w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
      nGrst = 0;
      tick();
      nGrst = 1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); chk("post_rst_no_valid", {30'd0, r0_valid, r1_valid}, 32'd0);
         tick();
      end
      w0_req = 1; w1_req = 1; w0_addr = 8'h50; w1_addr = 8'h51;
      r0_req = 1; r1_req = 1; r0_addr = 8'h52; r1_addr = 8'h53;
      @(negedge clk);
      chk("post_rst_w0_wins", {30'd0, w0_gnt, w1_gnt}, 32'd2);
      chk("post_rst_r0_wins", {30'd0, r0_gnt, r1_gnt}, 32'd2);
      tick();
      w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
      repeat (3) tick();

      // hazard counter saturation
      w0_req = 1; w0_addr = 8'h30; w0_data = 32'h3030;
      r0_req = 1; r0_addr = 8'h30;
      repeat (65540) tick();
      @(negedge clk);
      chk("haz_saturate", {16'd0, hazard_cnt}, 32'h0000FFFF);
      tick();
      w0_req = 0; r0_req = 0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
